fma_issue_sched: RTL and testbench

//  Issue scheduler for the shared fused multiply-add pipeline (multiply/align -> add/LOA -> normalize & round).
//  Two requesters share one pipeline: Req0 is the scalar FP path and Req1 is the secondary path.
//  The block round-robin arbitrates them, resolves the dynamic rounding mode, and tracks valid/id/tag per stage.
//  It freezes the pipe on output back-pressure, returns per-op exception flags and accumulates sticky fflags.

---
 rtl/fma_issue_sched.sv | 143 ++++++++++++++
 tb/tb_fma_issue_sched.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_issue_sched.sv
// Issue scheduler for the shared FMA pipeline: round-robin arbitration of two
// requesters, rounding-mode resolution, per-stage id/tag tracking and sticky fflags.
module fma_issue_sched #(
  parameter int unsigned          PARM_STAGES = 3,
  parameter int unsigned          PARM_RM     = 3,
  parameter int unsigned          PARM_TAG    = 4,
  parameter logic [PARM_RM-1:0]   PARM_RM_DYN = 3'b111
) (
  input  logic                Clk_i,
  input  logic                Rst_i,
  input  logic                Req0_valid_i,
  output logic                Req0_ready_o,
  input  logic [PARM_RM-1:0]  Req0_rm_i,
  input  logic [PARM_TAG-1:0] Req0_tag_i,
  input  logic                Req1_valid_i,
  output logic                Req1_ready_o,
  input  logic [PARM_RM-1:0]  Req1_rm_i,
  input  logic [PARM_TAG-1:0] Req1_tag_i,
  input  logic [PARM_RM-1:0]  Frm_i,
  output logic                Dp_issue_o,
  output logic                Dp_sel_o,
  output logic [PARM_RM-1:0]  Dp_rm_o,
  output logic                Dp_stall_o,
  input  logic [3:0]          Dp_flags_i,
  output logic                Rsp_valid_o,
  input  logic                Rsp_ready_i,
  output logic                Rsp_id_o,
  output logic [PARM_TAG-1:0] Rsp_tag_o,
  output logic [3:0]          Rsp_flags_o,
  output logic                Rsp_illegal_o,
  output logic [3:0]          Fflags_o,
  input  logic                Fflags_clr_i,
  output logic                Busy_o
);

  localparam int unsigned       LAST      = PARM_STAGES - 1;
  localparam int unsigned       TAG_W     = PARM_STAGES * PARM_TAG;
  localparam logic [PARM_RM-1:0] RM_ILL_LO = PARM_RM'(5);

  typedef enum logic {
    PTR_REQ0 = 1'b0,
    PTR_REQ1 = 1'b1
  } rr_ptr_e;

  rr_ptr_e                             ptr_q, ptr_d;
  logic [PARM_STAGES-1:0]              v_q, v_d;
  logic [PARM_STAGES-1:0]              id_q, id_d;
  logic [PARM_STAGES-1:0]              ill_q, ill_d;
  logic [PARM_STAGES-1:0][PARM_TAG-1:0] tag_q, tag_d;
  logic [3:0]                          fflags_q, fflags_d;

  logic                stall;
  logic                gnt0, gnt1, gnt_any, accept;
  logic [PARM_RM-1:0]  rm_req, rm_res;
  logic                rm_illegal;
  logic [PARM_TAG-1:0] tag_req;
  logic                rsp_hs;

  always_comb begin
    stall = v_q[LAST] & ~Rsp_ready_i;

    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (ptr_q == PTR_REQ0) begin
      gnt0 = Req0_valid_i;
      gnt1 = ~Req0_valid_i & Req1_valid_i;
    end else begin
      gnt1 = Req1_valid_i;
      gnt0 = ~Req1_valid_i & Req0_valid_i;
    end
    gnt_any = gnt0 | gnt1;
    accept  = gnt_any & ~stall;

    rm_req     = gnt1 ? Req1_rm_i : Req0_rm_i;
    tag_req    = gnt1 ? Req1_tag_i : Req0_tag_i;
    rm_res     = (rm_req == PARM_RM_DYN) ? Frm_i : rm_req;
    rm_illegal = gnt_any & (rm_res >= RM_ILL_LO);

    Req0_ready_o = gnt0 & ~stall;
    Req1_ready_o = gnt1 & ~stall;
    Dp_issue_o   = accept;
    Dp_sel_o     = gnt1;
    Dp_rm_o      = (gnt_any & ~rm_illegal) ? rm_res : '0;
    Dp_stall_o   = stall;

    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = gnt1 ? PTR_REQ0 : PTR_REQ1;
    end
  end

  // Stage 0 sits in the LSB slice; the cast drops the oldest stage as it shifts out.
  always_comb begin
    v_d   = v_q;
    id_d  = id_q;
    ill_d = ill_q;
    tag_d = tag_q;
    if (!stall) begin
      v_d   = PARM_STAGES'({v_q, accept});
      id_d  = PARM_STAGES'({id_q, accept & gnt1});
      ill_d = PARM_STAGES'({ill_q, accept & rm_illegal});
      tag_d = TAG_W'({tag_q, (accept ? tag_req : '0)});
    end
  end

  always_comb begin
    Rsp_valid_o   = v_q[LAST];
    Rsp_id_o      = id_q[LAST];
    Rsp_tag_o     = tag_q[LAST];
    Rsp_illegal_o = ill_q[LAST];
    // Gated on valid as well so an empty pipe reports no flags.
    Rsp_flags_o   = (v_q[LAST] & ~ill_q[LAST]) ? Dp_flags_i : '0;
    Busy_o        = |v_q;
    Fflags_o      = fflags_q;

    rsp_hs   = v_q[LAST] & Rsp_ready_i;
    fflags_d = fflags_q;
    if (Fflags_clr_i) begin
      fflags_d = rsp_hs ? Rsp_flags_o : '0;
    end else if (rsp_hs) begin
      fflags_d = fflags_q | Rsp_flags_o;
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      ptr_q    <= PTR_REQ0;
      v_q      <= '0;
      id_q     <= '0;
      ill_q    <= '0;
      tag_q    <= '0;
      fflags_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      v_q      <= v_d;
      id_q     <= id_d;
      ill_q    <= ill_d;
      tag_q    <= tag_d;
      fflags_q <= fflags_d;
    end
  end

endmodule

// File: tb/tb_fma_issue_sched.sv
// Directed bench for fma_issue_sched: reset, single op, contention, back-pressure,
// dynamic rounding mode, flag-clear collision and reset with ops in flight.
module tb_fma_issue_sched;

  logic       Clk_i = 1'b0;
  logic       Rst_i;
  logic       Req0_valid_i, Req0_ready_o;
  logic [2:0] Req0_rm_i;
  logic [3:0] Req0_tag_i;
  logic       Req1_valid_i, Req1_ready_o;
  logic [2:0] Req1_rm_i;
  logic [3:0] Req1_tag_i;
  logic [2:0] Frm_i;
  logic       Dp_issue_o, Dp_sel_o, Dp_stall_o;
  logic [2:0] Dp_rm_o;
  logic [3:0] Dp_flags_i;
  logic       Rsp_valid_o, Rsp_ready_i, Rsp_id_o, Rsp_illegal_o;
  logic [3:0] Rsp_tag_o, Rsp_flags_o, Fflags_o;
  logic       Fflags_clr_i, Busy_o;

  int checks = 0;
  int errors = 0;

  always #5 Clk_i = ~Clk_i;

  fma_issue_sched #(
    .PARM_STAGES(3),
    .PARM_RM    (3),
    .PARM_TAG   (4),
    .PARM_RM_DYN(3'b111)
  ) dut (
    .Clk_i        (Clk_i),
    .Rst_i        (Rst_i),
    .Req0_valid_i (Req0_valid_i),
    .Req0_ready_o (Req0_ready_o),
    .Req0_rm_i    (Req0_rm_i),
    .Req0_tag_i   (Req0_tag_i),
    .Req1_valid_i (Req1_valid_i),
    .Req1_ready_o (Req1_ready_o),
    .Req1_rm_i    (Req1_rm_i),
    .Req1_tag_i   (Req1_tag_i),
    .Frm_i        (Frm_i),
    .Dp_issue_o   (Dp_issue_o),
    .Dp_sel_o     (Dp_sel_o),
    .Dp_rm_o      (Dp_rm_o),
    .Dp_stall_o   (Dp_stall_o),
    .Dp_flags_i   (Dp_flags_i),
    .Rsp_valid_o  (Rsp_valid_o),
    .Rsp_ready_i  (Rsp_ready_i),
    .Rsp_id_o     (Rsp_id_o),
    .Rsp_tag_o    (Rsp_tag_o),
    .Rsp_flags_o  (Rsp_flags_o),
    .Rsp_illegal_o(Rsp_illegal_o),
    .Fflags_o     (Fflags_o),
    .Fflags_clr_i (Fflags_clr_i),
    .Busy_o       (Busy_o)
  );

  task automatic tick();
    @(posedge Clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    Req0_valid_i = 1'b0; Req0_rm_i = 3'b000; Req0_tag_i = 4'h0;
    Req1_valid_i = 1'b0; Req1_rm_i = 3'b000; Req1_tag_i = 4'h0;
    Frm_i = 3'b000; Dp_flags_i = 4'b0000; Rsp_ready_i = 1'b1; Fflags_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    Rst_i = 1'b1;
    #3;
    checks++; if (Rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", Rsp_valid_o); end
    checks++; if (Busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy_o); end
    checks++; if (Fflags_o !== 4'b0000) begin errors++; $display("FAIL reset_fflags: got %b expected 0000", Fflags_o); end
    checks++; if (Dp_rm_o !== 3'b000) begin errors++; $display("FAIL reset_dp_rm: got %b expected 000", Dp_rm_o); end
    checks++; if ({Dp_issue_o, Dp_stall_o, Req0_ready_o, Req1_ready_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {Dp_issue_o, Dp_stall_o, Req0_ready_o, Req1_ready_o});
    end
    tick();
    Rst_i = 1'b0;
  endtask

  task automatic test_single();
    idle();
    Req0_valid_i = 1'b1; Req0_tag_i = 4'h5; Req0_rm_i = 3'b000;
    settle();
    checks++; if ({Req0_ready_o, Dp_issue_o, Dp_sel_o} !== 3'b110) begin
      errors++; $display("FAIL single_issue: got %b expected 110", {Req0_ready_o, Dp_issue_o, Dp_sel_o});
    end
    tick();
    Req0_valid_i = 1'b0;
    settle();
    checks++; if ({Rsp_valid_o, Busy_o} !== 2'b01) begin errors++; $display("FAIL single_c1: got %b expected 01", {Rsp_valid_o, Busy_o}); end
    tick();
    settle();
    checks++; if (Rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_c2: got %b expected 0", Rsp_valid_o); end
    tick();
    Dp_flags_i = 4'b0001;
    settle();
    checks++; if ({Rsp_valid_o, Rsp_id_o, Rsp_tag_o} !== 6'b10_0101) begin
      errors++; $display("FAIL single_rsp: got %b expected 100101", {Rsp_valid_o, Rsp_id_o, Rsp_tag_o});
    end
    checks++; if (Rsp_flags_o !== 4'b0001) begin errors++; $display("FAIL single_flags: got %b expected 0001", Rsp_flags_o); end
    tick();
    Dp_flags_i = 4'b0000;
    settle();
    checks++; if (Fflags_o !== 4'b0001) begin errors++; $display("FAIL single_fflags: got %b expected 0001", Fflags_o); end
    checks++; if ({Rsp_valid_o, Busy_o} !== 2'b00) begin errors++; $display("FAIL single_drain: got %b expected 00", {Rsp_valid_o, Busy_o}); end
  endtask

  task automatic test_contention();
    logic [3:0] tag0, tag1;
    logic       exp_sel;
    idle();
    Rst_i = 1'b1; #2; Rst_i = 1'b0;
    tick();
    tag0 = 4'd0; tag1 = 4'd1;
    for (int i = 0; i < 11; i++) begin
      Req0_valid_i = (i < 8); Req1_valid_i = (i < 8);
      Req0_tag_i = tag0; Req1_tag_i = tag1;
      settle();
      if (i < 8) begin
        exp_sel = 1'(i % 2);
        checks++; if ({Dp_issue_o, Dp_sel_o} !== {1'b1, exp_sel}) begin
          errors++; $display("FAIL cont_grant[%0d]: got %b expected %b", i, {Dp_issue_o, Dp_sel_o}, {1'b1, exp_sel});
        end
        checks++; if ({Req0_ready_o, Req1_ready_o} !== {~exp_sel, exp_sel}) begin
          errors++; $display("FAIL cont_ready[%0d]: got %b expected %b", i, {Req0_ready_o, Req1_ready_o}, {~exp_sel, exp_sel});
        end
        if (exp_sel) tag1 = tag1 + 4'd2; else tag0 = tag0 + 4'd2;
      end
      if (i >= 3) begin
        checks++; if ({Rsp_valid_o, Rsp_id_o, Rsp_tag_o} !== {1'b1, 1'((i - 3) % 2), 4'(i - 3)}) begin
          errors++; $display("FAIL cont_rsp[%0d]: got %b expected %b", i, {Rsp_valid_o, Rsp_id_o, Rsp_tag_o},
                             {1'b1, 1'((i - 3) % 2), 4'(i - 3)});
        end
      end
      tick();
    end
    idle();
    settle();
    checks++; if ({Rsp_valid_o, Busy_o} !== 2'b00) begin errors++; $display("FAIL cont_drain: got %b expected 00", {Rsp_valid_o, Busy_o}); end
  endtask

  task automatic test_back_pressure();
    idle();
    for (int k = 0; k < 3; k++) begin
      Req0_valid_i = 1'b1; Req0_tag_i = 4'(8 + k);
      settle();
      checks++; if (Dp_issue_o !== 1'b1) begin errors++; $display("FAIL bp_fill[%0d]: got %b expected 1", k, Dp_issue_o); end
      tick();
    end
    Req0_tag_i = 4'd11; Req1_valid_i = 1'b1; Req1_tag_i = 4'd12; Rsp_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if ({Dp_stall_o, Req0_ready_o, Req1_ready_o, Dp_issue_o} !== 4'b1000) begin
        errors++; $display("FAIL bp_stall[%0d]: got %b expected 1000", k, {Dp_stall_o, Req0_ready_o, Req1_ready_o, Dp_issue_o});
      end
      checks++; if ({Rsp_valid_o, Rsp_id_o, Rsp_tag_o} !== 6'b10_1000) begin
        errors++; $display("FAIL bp_hold[%0d]: got %b expected 101000", k, {Rsp_valid_o, Rsp_id_o, Rsp_tag_o});
      end
      tick();
    end
    Req1_valid_i = 1'b0; Rsp_ready_i = 1'b1;
    settle();
    checks++; if ({Dp_stall_o, Req0_ready_o, Dp_issue_o, Rsp_tag_o} !== 7'b011_1000) begin
      errors++; $display("FAIL bp_release: got %b expected 0111000", {Dp_stall_o, Req0_ready_o, Dp_issue_o, Rsp_tag_o});
    end
    tick();
    Req0_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if ({Rsp_valid_o, Rsp_tag_o} !== {1'b1, 4'(9 + k)}) begin
        errors++; $display("FAIL bp_after[%0d]: got %b expected %b", k, {Rsp_valid_o, Rsp_tag_o}, {1'b1, 4'(9 + k)});
      end
      tick();
    end
    settle();
    checks++; if (Rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", Rsp_valid_o); end
  endtask

  task automatic test_dynamic_rm();
    idle();
    Req1_valid_i = 1'b1; Req1_rm_i = 3'b111; Frm_i = 3'b010; Req1_tag_i = 4'd3;
    settle();
    checks++; if ({Dp_issue_o, Dp_sel_o, Req1_ready_o, Dp_rm_o} !== 6'b111_010) begin
      errors++; $display("FAIL dyn_rm_legal: got %b expected 111010", {Dp_issue_o, Dp_sel_o, Req1_ready_o, Dp_rm_o});
    end
    tick();
    Frm_i = 3'b101; Req1_tag_i = 4'd4;
    settle();
    checks++; if ({Dp_issue_o, Dp_rm_o} !== 4'b1_000) begin
      errors++; $display("FAIL dyn_rm_illegal: got %b expected 1000", {Dp_issue_o, Dp_rm_o});
    end
    tick();
    Req1_valid_i = 1'b0; Frm_i = 3'b000;
    tick();
    Dp_flags_i = 4'b0100;
    settle();
    checks++; if ({Rsp_valid_o, Rsp_id_o, Rsp_tag_o, Rsp_illegal_o, Rsp_flags_o} !== 11'b1_1_0011_0_0100) begin
      errors++; $display("FAIL dyn_rsp_a: got %b expected 11001100100", {Rsp_valid_o, Rsp_id_o, Rsp_tag_o, Rsp_illegal_o, Rsp_flags_o});
    end
    tick();
    Dp_flags_i = 4'b1111;
    settle();
    checks++; if ({Rsp_valid_o, Rsp_id_o, Rsp_tag_o, Rsp_illegal_o, Rsp_flags_o} !== 11'b1_1_0100_1_0000) begin
      errors++; $display("FAIL dyn_rsp_b: got %b expected 11010010000", {Rsp_valid_o, Rsp_id_o, Rsp_tag_o, Rsp_illegal_o, Rsp_flags_o});
    end
    tick();
    Dp_flags_i = 4'b0000;
    settle();
    checks++; if (Fflags_o !== 4'b0100) begin errors++; $display("FAIL dyn_fflags: got %b expected 0100", Fflags_o); end
  endtask

  task automatic test_clear_collision();
    idle();
    Fflags_clr_i = 1'b1;
    tick();
    Fflags_clr_i = 1'b0;
    settle();
    checks++; if (Fflags_o !== 4'b0000) begin errors++; $display("FAIL clr_plain: got %b expected 0000", Fflags_o); end
    Req0_valid_i = 1'b1; Req0_tag_i = 4'd1;
    tick();
    Req0_tag_i = 4'd2;
    tick();
    Req0_valid_i = 1'b0;
    tick();
    Dp_flags_i = 4'b1000;
    settle();
    checks++; if ({Rsp_valid_o, Rsp_tag_o} !== 5'b1_0001) begin errors++; $display("FAIL clr_rsp1: got %b expected 10001", {Rsp_valid_o, Rsp_tag_o}); end
    tick();
    settle();
    checks++; if (Fflags_o !== 4'b1000) begin errors++; $display("FAIL clr_accum: got %b expected 1000", Fflags_o); end
    Dp_flags_i = 4'b0010; Fflags_clr_i = 1'b1;
    #1;
    checks++; if ({Rsp_valid_o, Rsp_tag_o} !== 5'b1_0010) begin errors++; $display("FAIL clr_rsp2: got %b expected 10010", {Rsp_valid_o, Rsp_tag_o}); end
    tick();
    Fflags_clr_i = 1'b0; Dp_flags_i = 4'b0000;
    settle();
    checks++; if (Fflags_o !== 4'b0010) begin errors++; $display("FAIL clr_collision: got %b expected 0010", Fflags_o); end
  endtask

  task automatic test_reset_mid_pipe();
    idle();
    Req0_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      Req0_tag_i = 4'(12 + k);
      tick();
    end
    Req0_valid_i = 1'b0;
    settle();
    checks++; if ({Rsp_valid_o, Busy_o, Rsp_tag_o} !== 6'b11_1100) begin
      errors++; $display("FAIL rmid_full: got %b expected 111100", {Rsp_valid_o, Busy_o, Rsp_tag_o});
    end
    Rst_i = 1'b1;
    #1;
    checks++; if ({Rsp_valid_o, Busy_o, Fflags_o} !== 6'b00_0000) begin
      errors++; $display("FAIL rmid_async: got %b expected 000000", {Rsp_valid_o, Busy_o, Fflags_o});
    end
    Rst_i = 1'b0;
    tick();
    Req0_valid_i = 1'b1; Req1_valid_i = 1'b1; Req0_tag_i = 4'd7; Req1_tag_i = 4'd9;
    settle();
    checks++; if ({Dp_issue_o, Dp_sel_o} !== 2'b10) begin errors++; $display("FAIL rmid_ptr: got %b expected 10", {Dp_issue_o, Dp_sel_o}); end
    tick();
    Req0_valid_i = 1'b0; Req1_valid_i = 1'b0;
    settle();
    checks++; if (Rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_c1: got %b expected 0", Rsp_valid_o); end
    tick();
    settle();
    checks++; if (Rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_c2: got %b expected 0", Rsp_valid_o); end
    tick();
    settle();
    checks++; if ({Rsp_valid_o, Rsp_id_o, Rsp_tag_o} !== 6'b10_0111) begin
      errors++; $display("FAIL rmid_rsp: got %b expected 100111", {Rsp_valid_o, Rsp_id_o, Rsp_tag_o});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_dynamic_rm();
    test_clear_collision();
    test_reset_mid_pipe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
